// File: rtl/timer_pkg.sv
// timer_pkg: register map, CTRL/STATUS bit positions and FSM states shared by
// the timer controller and its prescaler.
package timer_pkg;

   localparam int TMR_CTRL = 0;
   localparam int TMR_LOAD = 1;
   localparam int TMR_CMP  = 2;
   localparam int TMR_PSC  = 3;
   localparam int TMR_STAT = 4;
   localparam int TMR_MISS = 5;

   localparam int CTRL_EN       = 0;
   localparam int CTRL_PERIODIC = 1;
   localparam int CTRL_IRQEN    = 2;

   localparam int STAT_PEND    = 0;
   localparam int STAT_RUNNING = 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } tmr_state_e;

endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: free-running 0..PSC divider producing a one-cycle tick on
// wrap; a new PSC value is adopted only at a wrap or on clear.
module timer_prescaler
   import timer_pkg::*;
#(
   parameter int PSC_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             psc_we,
   input  logic [PSC_W-1:0] psc_wdata,
   input  logic             clear,
   output logic [PSC_W-1:0] psc,
   output logic             tick
);

   logic [PSC_W-1:0] psc_act;
   logic [PSC_W-1:0] pc;
   logic [PSC_W-1:0] psc_next;

   assign psc_next = psc_we ? psc_wdata : psc;
   assign tick     = (pc == psc_act);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         psc     <= '0;
         psc_act <= '0;
         pc      <= '0;
      end else begin
         psc <= psc_next;
         if (clear || tick) begin
            pc      <= '0;
            psc_act <= psc_next;
         end else begin
            pc <= pc + 1'b1;
         end
      end
   end

endmodule

// File: rtl/timer_ctrl.sv
// timer_ctrl: register-programmed one-shot/periodic sequencer for the timer
// counter. The MISS counter is built only when TIMER_CTRL_MISS_CNT_EN is defined.
module timer_ctrl
   import timer_pkg::*;
#(
   parameter int CNT_W  = 32,
   parameter int PSC_W  = 16,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wrEn,
   input  logic              rdEn,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wrData,
   output logic [31:0]       rdData,
   output logic              rdValid,
   output logic [CNT_W-1:0]  initialLoad,
   output logic [CNT_W-1:0]  coValLoad,
   output logic              init,
   output logic              cntEn,
   input  logic              co,
   output logic              irq,
   output logic              running,
   output tmr_state_e        fsm_state
);

   // Bus: wrEn/rdEn are single-cycle strobes, always accepted; rdValid pulses
   // exactly one cycle after rdEn with rdData sampled from pre-write state.
   tmr_state_e       state, state_next;
   logic             wr_ctrl, wr_load, wr_cmp, wr_psc, wr_stat;
   logic             en_on, en_off, co_run, clr_pend, copy_act, tick;
   logic             ctrl_en, ctrl_per, ctrl_ie, pend;
   logic [CNT_W-1:0] load_sh, cmp_sh, load_next, cmp_next;
   logic [PSC_W-1:0] psc_val;
   logic [31:0]      rd_mux, miss_val;

   assign wr_ctrl  = wrEn && (addr == ADDR_W'(TMR_CTRL));
   assign wr_load  = wrEn && (addr == ADDR_W'(TMR_LOAD));
   assign wr_cmp   = wrEn && (addr == ADDR_W'(TMR_CMP));
   assign wr_psc   = wrEn && (addr == ADDR_W'(TMR_PSC));
   assign wr_stat  = wrEn && (addr == ADDR_W'(TMR_STAT));
   assign en_on    = wr_ctrl && wrData[CTRL_EN];
   assign en_off   = wr_ctrl && !wrData[CTRL_EN];
   assign co_run   = co && (state == RUN);
   assign clr_pend = wr_stat && wrData[STAT_PEND];

   timer_prescaler #(.PSC_W(PSC_W)) u_psc (
      .clk       (clk),
      .rst       (rst),
      .psc_we    (wr_psc),
      .psc_wdata (wrData[PSC_W-1:0]),
      .clear     (state == ARM),
      .psc       (psc_val),
      .tick      (tick)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE, DONE: if (en_on) state_next = ARM;
         ARM:        state_next = en_off ? IDLE : RUN;
         RUN: begin
            if (en_off)                  state_next = IDLE;
            else if (co && !ctrl_per)    state_next = DONE;
         end
         default:    state_next = IDLE;
      endcase
   end

   always_comb begin
      init    = (state == ARM);
      cntEn   = (state == RUN) && tick;
      running = (state == ARM) || (state == RUN);
   end

   assign fsm_state = state;
   assign irq       = pend && ctrl_ie;

   // Active values follow the shadows except mid-period, where they move only at co.
   assign load_next = wr_load ? wrData[CNT_W-1:0] : load_sh;
   assign cmp_next  = wr_cmp  ? wrData[CNT_W-1:0] : cmp_sh;
   assign copy_act  = (state != RUN) || co_run;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ctrl_en     <= 1'b0;
         ctrl_per    <= 1'b0;
         ctrl_ie     <= 1'b0;
         pend        <= 1'b0;
         load_sh     <= '0;
         cmp_sh      <= '0;
         initialLoad <= '0;
         coValLoad   <= '0;
      end else begin
         if (wr_ctrl) begin
            ctrl_en  <= wrData[CTRL_EN];
            ctrl_per <= wrData[CTRL_PERIODIC];
            ctrl_ie  <= wrData[CTRL_IRQEN];
         end
         if (co_run && !ctrl_per) ctrl_en <= 1'b0;
         if (co_run)        pend <= 1'b1;
         else if (clr_pend) pend <= 1'b0;
         load_sh <= load_next;
         cmp_sh  <= cmp_next;
         if (copy_act) begin
            initialLoad <= load_next;
            coValLoad   <= cmp_next;
         end
      end
   end

`ifdef TIMER_CTRL_MISS_CNT_EN
   logic [7:0] miss;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         miss <= '0;
      end else if (co_run && pend) begin
         if (miss != 8'hFF) miss <= miss + 8'd1;
      end else if (clr_pend) begin
         miss <= '0;
      end
   end

   assign miss_val = {24'b0, miss};
`else
   assign miss_val = '0;
`endif

   always_comb begin
      rd_mux = '0;
      case (addr)
         ADDR_W'(TMR_CTRL): begin
            rd_mux[CTRL_EN]       = ctrl_en;
            rd_mux[CTRL_PERIODIC] = ctrl_per;
            rd_mux[CTRL_IRQEN]    = ctrl_ie;
         end
         ADDR_W'(TMR_LOAD): rd_mux = 32'(load_sh);
         ADDR_W'(TMR_CMP):  rd_mux = 32'(cmp_sh);
         ADDR_W'(TMR_PSC):  rd_mux = 32'(psc_val);
         ADDR_W'(TMR_STAT): begin
            rd_mux[STAT_PEND]    = pend;
            rd_mux[STAT_RUNNING] = running;
         end
         ADDR_W'(TMR_MISS): rd_mux = miss_val;
         default:           rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdData  <= '0;
         rdValid <= 1'b0;
      end else begin
         rdValid <= rdEn;
         if (rdEn) rdData <= rd_mux;
      end
   end

endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: directed scenarios plus randomized bus/co traffic, checked
// every cycle against a behavioural model of the timer controller.
module tb_timer_ctrl;
   import timer_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wrEn = 1'b0, rdEn = 1'b0, co = 1'b0;
   logic [2:0]  addr = '0;
   logic [31:0] wrData = '0;
   logic [31:0] rdData, initialLoad, coValLoad;
   logic        rdValid, init, cntEn, irq, running;
   tmr_state_e  fsm_state;

   always #5 clk = ~clk;

   timer_ctrl #(.CNT_W(32), .PSC_W(16), .ADDR_W(3)) dut (
      .clk(clk), .rst(rst), .wrEn(wrEn), .rdEn(rdEn), .addr(addr), .wrData(wrData),
      .rdData(rdData), .rdValid(rdValid), .initialLoad(initialLoad), .coValLoad(coValLoad),
      .init(init), .cntEn(cntEn), .co(co), .irq(irq), .running(running), .fsm_state(fsm_state)
   );

   int n_checks = 0;
   int n_errors = 0;
   bit chk_on = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model: phase names, a divide-by-(PSC+1) phase counter and plain registers.
   localparam int P_IDLE = 0, P_ARM = 1, P_RUN = 2, P_DONE = 3;
   int          m_phase, m_since, m_div, m_miss;
   bit          m_en, m_per, m_ie, m_pend, m_rdv;
   logic [31:0] m_lsh, m_csh, m_lact, m_cact, m_rd;
   logic [15:0] m_psc;

   function automatic tmr_state_e phase_enum(input int p);
      case (p)
         P_ARM:   return ARM;
         P_RUN:   return RUN;
         P_DONE:  return DONE;
         default: return IDLE;
      endcase
   endfunction

   function automatic logic [31:0] read_view(input int a);
      case (a)
         0: return {29'b0, m_ie, m_per, m_en};
         1: return m_lsh;
         2: return m_csh;
         3: return {16'b0, m_psc};
         4: return {30'b0, (m_phase == P_ARM || m_phase == P_RUN), m_pend};
`ifdef TIMER_CTRL_MISS_CNT_EN
         5: return 32'(m_miss);
`endif
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_reset();
      m_phase = P_IDLE; m_since = 0; m_div = 1; m_miss = 0;
      m_en = 0; m_per = 0; m_ie = 0; m_pend = 0; m_rdv = 0;
      m_lsh = 0; m_csh = 0; m_lact = 0; m_cact = 0; m_rd = 0; m_psc = 0;
   endtask

   task automatic model_step();
      int          a = int'(addr);
      bit          wr_c = wrEn && a == 0;
      bit          wr_s = wrEn && a == 4;
      bit          co_now = co && m_phase == P_RUN;
      bit          wrap = (m_since == m_div - 1);
      bit          old_per = m_per;
      int          nphase = m_phase;
      logic [15:0] new_psc = (wrEn && a == 3) ? wrData[15:0] : m_psc;
      m_rdv = rdEn;
      if (rdEn) m_rd = read_view(a);
      if ((m_phase == P_IDLE || m_phase == P_DONE) && wr_c && wrData[0]) nphase = P_ARM;
      else if (m_phase == P_ARM) nphase = (wr_c && !wrData[0]) ? P_IDLE : P_RUN;
      else if (m_phase == P_RUN) begin
         if (wr_c && !wrData[0])     nphase = P_IDLE;
         else if (co_now && !old_per) nphase = P_DONE;
      end
      if (m_phase == P_ARM || wrap) begin
         m_since = 0;
         m_div   = int'(new_psc) + 1;
      end else begin
         m_since++;
      end
      if (wrEn && a == 1) m_lsh = wrData;
      if (wrEn && a == 2) m_csh = wrData;
      if (m_phase != P_RUN || co_now) begin
         m_lact = m_lsh;
         m_cact = m_csh;
      end
      if (wr_c) begin
         m_en = wrData[0]; m_per = wrData[1]; m_ie = wrData[2];
      end
      if (co_now && !old_per) m_en = 0;
      if (co_now) begin
         if (m_pend) m_miss = (m_miss < 255) ? m_miss + 1 : 255;
         m_pend = 1;
      end else if (wr_s && wrData[0]) begin
         m_pend = 0;
         m_miss = 0;
      end
      m_psc   = new_psc;
      m_phase = nphase;
   endtask

   initial model_reset();

   always @(posedge clk or negedge rst) begin
      if (!rst) model_reset();
      else      model_step();
   end

   // Compare process: every output against the model, once per cycle.
   always @(negedge clk) begin
      if (chk_on) begin
         chk("init", 32'(init), 32'(m_phase == P_ARM));
         chk("cntEn", 32'(cntEn), 32'(m_phase == P_RUN && m_since == m_div - 1));
         chk("running", 32'(running), 32'(m_phase == P_ARM || m_phase == P_RUN));
         chk("irq", 32'(irq), 32'(m_pend && m_ie));
         chk("initialLoad", initialLoad, m_lact);
         chk("coValLoad", coValLoad, m_cact);
         chk("rdValid", 32'(rdValid), 32'(m_rdv));
         chk("rdData", rdData, m_rd);
         chk("fsm_state", 32'(fsm_state), 32'(phase_enum(m_phase)));
      end
   end

   // Environment counter model drives co in directed phases.
   logic [31:0] env_cnt = '0;
   bit          co_auto = 1'b1;
   int          co_pct = 20;
   int          cyc = 0, cnten_seen = 0, co_seen = 0, init_seen = 0, last_co_cyc = 0, co_gap = 0;

   function automatic bit co_pred();
      return cntEn && (env_cnt == coValLoad);
   endfunction

   task automatic drive(input bit w, input bit r, input int a, input logic [31:0] d);
      logic        s_init, s_cen;
      logic [31:0] s_load, s_cmp;
      wrEn = w; rdEn = r; addr = 3'(a); wrData = d;
      co = co_auto ? co_pred() : ($urandom_range(0, 99) < co_pct);
      s_init = init; s_cen = cntEn; s_load = initialLoad; s_cmp = coValLoad;
      if (cntEn) cnten_seen++;
      if (init)  init_seen++;
      if (co) begin
         co_seen++;
         co_gap = cyc - last_co_cyc;
         last_co_cyc = cyc;
      end
      @(posedge clk);
      if (s_init)     env_cnt = s_load;
      else if (s_cen) env_cnt = (env_cnt == s_cmp) ? s_load : env_cnt + 1;
      cyc++;
      @(negedge clk);
   endtask

   task automatic nop();
      drive(0, 0, 0, 0);
   endtask

   task automatic wr(input int a, input logic [31:0] d);
      drive(1, 0, a, d);
   endtask

   task automatic rd_chk(input string name, input int a, input logic [31:0] exp);
      drive(0, 1, a, 0);
      chk(name, rdData, exp);
   endtask

   task automatic wait_co_pred(input int bound);
      int k = 0;
      while (!co_pred() && k < bound) begin
         nop();
         k++;
      end
      chk("co_wait", 32'(co_pred()), 32'd1);
   endtask

   task automatic wait_co_seen(input int target, input int bound);
      int k = 0;
      while (co_seen < target && k < bound) begin
         nop();
         k++;
      end
      chk("co_seen", 32'(co_seen >= target), 32'd1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation still running, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      #1 rst = 1'b0;
      chk_on = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_init", 32'(init), 0);
      chk("rst_cnten", 32'(cntEn), 0);
      chk("rst_irq", 32'(irq), 0);
      chk("rst_running", 32'(running), 0);
      chk("rst_rdvalid", 32'(rdValid), 0);
      chk("rst_state", 32'(fsm_state), 32'(IDLE));
      rst = 1'b1;

      // One-shot, PSC=0
      wr(1, 0); wr(2, 9); wr(3, 0); wr(0, 5);
      chk("os_init", 32'(init), 1);
      chk("os_cnten_n1", 32'(cntEn), 0);
      cnten_seen = 0; co_seen = 0;
      nop();
      chk("os_first_cnten", 32'(cntEn), 1);
      wait_co_seen(1, 100);
      chk("os_cnten_to_co", 32'(cnten_seen), 10);
      chk("os_irq", 32'(irq), 1);
      chk("os_state", 32'(fsm_state), 32'(DONE));
      chk("os_cmp", coValLoad, 9);
      rd_chk("os_ctrl_en0", 0, 32'h4);

      // Periodic with prescaler
      wr(1, 2); wr(2, 5); wr(3, 3); wr(4, 1); wr(0, 7);
      wait_co_seen(co_seen + 1, 200);
      chk("per_irq", 32'(irq), 1);
      wait_co_seen(co_seen + 1, 200);
      chk("per_gap", 32'(co_gap), 16);
      wr(4, 1);
      chk("per_clr_irq", 32'(irq), 0);
      wait_co_seen(co_seen + 1, 200);
      chk("per_gap2", 32'(co_gap), 16);
      chk("per_irq_again", 32'(irq), 1);

      // Shadowed COMPARE update
      wr(2, 20);
      chk("shadow_hold", coValLoad, 5);
      wait_co_pred(100);
      chk("shadow_hold_co", coValLoad, 5);
      nop();
      chk("shadow_new", coValLoad, 20);

      // Coincident events
      wait_co_pred(200);
      wr(4, 1);
      chk("sim_clr_irq", 32'(irq), 1);
      rd_chk("sim_clr_stat", 4, 32'h3);
      wr(4, 1);
      chk("sim_pre_irq", 32'(irq), 0);
      wait_co_pred(200);
      wr(0, 4);
      chk("sim_en0_state", 32'(fsm_state), 32'(IDLE));
      chk("sim_en0_irq", 32'(irq), 1);
      chk("sim_en0_running", 32'(running), 0);
      rd_chk("sim_en0_stat", 4, 32'h1);

      // Asynchronous reset mid-RUN
      wr(1, 5); wr(2, 9); wr(3, 0); wr(0, 3);
      repeat (4) nop();
      chk("rst_pre_load", initialLoad, 5);
      chk("rst_pre_running", 32'(running), 1);
      #2 rst = 1'b0;
      #1;
      chk("arst_init", 32'(init), 0);
      chk("arst_cnten", 32'(cntEn), 0);
      chk("arst_running", 32'(running), 0);
      chk("arst_load", initialLoad, 0);
      chk("arst_state", 32'(fsm_state), 32'(IDLE));
      @(negedge clk);
      rst = 1'b1;
      init_seen = 0;
      repeat (20) nop();
      chk("arst_no_init", 32'(init_seen), 0);

      // Same-cycle read/write and reserved space
      wr(1, 32'h11);
      drive(1, 1, 1, 32'h22);
      chk("rw_old", rdData, 32'h11);
      rd_chk("rw_new", 1, 32'h22);
      wr(6, 32'hFFFF_FFFF);
      rd_chk("rsvd6", 6, 0);
      rd_chk("rsvd7", 7, 0);

`ifdef TIMER_CTRL_MISS_CNT_EN
      wr(1, 7); wr(2, 7); wr(3, 0); wr(0, 3);
      repeat (300) nop();
      rd_chk("miss_sat", 5, 255);
      wr(0, 0); wr(4, 1);
      rd_chk("miss_clr", 5, 0);
`else
      rd_chk("miss_absent", 5, 0);
`endif

      // Randomized bus traffic with random co
      co_auto = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3: nop();
            4: wr(0, $urandom_range(0, 7));
            5: wr(4, $urandom_range(0, 3));
            6: wr($urandom_range(1, 2), $urandom_range(0, 15));
            7: wr(3, $urandom_range(0, 3));
            8: drive(0, 1, $urandom_range(0, 7), 0);
            default: drive(1, 1, $urandom_range(0, 7), $urandom);
         endcase
      end
      co_auto = 1'b1;
      nop();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
